// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl
//   Front end for the byte-serial AES-128 core. Takes a 128-bit key and a 128-bit
//   plaintext block over a valid/ready handshake. It then resets the core and
//   streams the 16 key/data byte pairs into the core's load phase. The core's 16
//   ciphertext bytes, qualified by core_dvalid, are gathered and returned as one
//   128-bit word over a second valid/ready handshake. A watchdog aborts a job
//   that stalls in WAIT/COLLECT. That job ends with out_err=1 and out_data=0.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   job request handshake; in_key/in_block are byte 0 at [127:120]
//   out_valid/out_ready result handshake; out_data is the first captured byte at [127:120]
//   out_err             result is a timeout abort, out_data forced to zero
//   busy                a job is in flight
//   core_rst            synchronous reset to the core (high whenever no job runs)
//   core_key/core_data  load-phase bytes to the core
//   core_dout/core_dvalid ciphertext byte stream from the core
//
// State table
//   IDLE    | waiting for a job, core held in reset
//   CRST    | core_rst held high for RST_CYC cycles
//   LOAD    | 16 cycles of key/data bytes to the core
//   WAIT    | core running, no ciphertext byte seen yet
//   COLLECT | gathering ciphertext bytes 1..15
//   HOLD    | result presented until the consumer takes it
module aes_stream_ctrl #(
  parameter int RST_CYC     = 2,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_key,
  input  logic [127:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_err,
  output logic         busy,
  output logic         core_rst,
  output logic [7:0]   core_key,
  output logic [7:0]   core_data,
  input  logic [7:0]   core_dout,
  input  logic         core_dvalid
);

  typedef enum logic [2:0] {S_IDLE, S_CRST, S_LOAD, S_WAIT, S_COLLECT, S_HOLD} state_t;

  localparam logic [9:0] RST_LAST = 10'(RST_CYC - 1);
  localparam logic [9:0] TMO      = 10'(TIMEOUT_CYC);

  state_t       state, state_nx;
  logic [127:0] key_q, key_nx, blk_q, blk_nx, res_q, res_nx;
  logic [3:0]   bcnt, bcnt_nx;
  logic [9:0]   tcnt, tcnt_nx, tcnt_inc;
  logic         in_ready_nx, out_valid_nx, out_err_nx, busy_nx, core_rst_nx;
  logic [127:0] out_data_nx;
  logic [7:0]   core_key_nx, core_data_nx;

  // tcnt counts the CRST cycles as well as the WAIT/COLLECT watchdog; it is
  // cleared between the two uses.
  always_comb begin
    state_nx     = state;
    key_nx       = key_q;
    blk_nx       = blk_q;
    res_nx       = res_q;
    bcnt_nx      = bcnt;
    tcnt_nx      = tcnt;
    tcnt_inc     = tcnt + 10'd1;
    in_ready_nx  = 1'b0;
    out_valid_nx = 1'b0;
    out_err_nx   = out_err;
    out_data_nx  = out_data;
    core_rst_nx  = 1'b1;
    core_key_nx  = 8'h00;
    core_data_nx = 8'h00;

    unique case (state)
      S_IDLE: begin
        in_ready_nx = 1'b1;
        if (in_valid && in_ready) begin
          key_nx      = in_key;
          blk_nx      = in_block;
          tcnt_nx     = 10'd0;
          in_ready_nx = 1'b0;
          state_nx    = S_CRST;
        end
      end
      S_CRST: begin
        if (tcnt == RST_LAST) begin
          state_nx     = S_LOAD;
          bcnt_nx      = 4'd0;
          tcnt_nx      = 10'd0;
          core_rst_nx  = 1'b0;
          core_key_nx  = key_q[127:120];
          core_data_nx = blk_q[127:120];
        end else begin
          tcnt_nx = tcnt_inc;
        end
      end
      S_LOAD: begin
        core_rst_nx = 1'b0;
        if (bcnt == 4'd15) begin
          state_nx = S_WAIT;
          bcnt_nx  = 4'd0;
          tcnt_nx  = 10'd0;
        end else begin
          bcnt_nx      = bcnt + 4'd1;
          // byte k sits at bit 127-8k = {~k, 3'b111}
          core_key_nx  = key_q[{~bcnt_nx, 3'b111} -: 8];
          core_data_nx = blk_q[{~bcnt_nx, 3'b111} -: 8];
        end
      end
      S_WAIT, S_COLLECT: begin
        core_rst_nx = 1'b0;
        tcnt_nx     = tcnt_inc;
        if (core_dvalid) begin
          res_nx   = {res_q[119:0], core_dout};
          bcnt_nx  = bcnt + 4'd1;
          state_nx = S_COLLECT;
        end
        // A last byte arriving on the timeout edge still completes the job.
        if (core_dvalid && bcnt == 4'd15) begin
          state_nx     = S_HOLD;
          out_valid_nx = 1'b1;
          out_err_nx   = 1'b0;
          out_data_nx  = {res_q[119:0], core_dout};
          core_rst_nx  = 1'b1;
        end else if (tcnt_inc == TMO) begin
          state_nx     = S_HOLD;
          out_valid_nx = 1'b1;
          out_err_nx   = 1'b1;
          out_data_nx  = 128'd0;
          core_rst_nx  = 1'b1;
        end
      end
      S_HOLD: begin
        out_valid_nx = 1'b1;
        if (out_valid && out_ready) begin
          state_nx     = S_IDLE;
          out_valid_nx = 1'b0;
          out_err_nx   = 1'b0;
          out_data_nx  = 128'd0;
          in_ready_nx  = 1'b1;
        end
      end
      default: begin
        state_nx    = S_IDLE;
        in_ready_nx = 1'b1;
        out_err_nx  = 1'b0;
        out_data_nx = 128'd0;
      end
    endcase

    busy_nx = (state_nx != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      key_q     <= 128'd0;
      blk_q     <= 128'd0;
      res_q     <= 128'd0;
      bcnt      <= 4'd0;
      tcnt      <= 10'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      out_data  <= 128'd0;
      busy      <= 1'b0;
      core_rst  <= 1'b1;
      core_key  <= 8'h00;
      core_data <= 8'h00;
    end else begin
      state     <= state_nx;
      key_q     <= key_nx;
      blk_q     <= blk_nx;
      res_q     <= res_nx;
      bcnt      <= bcnt_nx;
      tcnt      <= tcnt_nx;
      in_ready  <= in_ready_nx;
      out_valid <= out_valid_nx;
      out_err   <= out_err_nx;
      out_data  <= out_data_nx;
      busy      <= busy_nx;
      core_rst  <= core_rst_nx;
      core_key  <= core_key_nx;
      core_data <= core_data_nx;
    end
  end

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// tb_aes_stream_ctrl
//   Drives aes_stream_ctrl with directed and random jobs. A core model captures the
//   16 load bytes. It answers with a ciphertext that is a pure function of the
//   key/plaintext it saw, using random latency and random dvalid gaps. The expected
//   result is that same function applied to the key/plaintext the bench submitted.
module tb_aes_stream_ctrl;

  localparam int TB_RST = 2;
  localparam int TB_TMO = 64;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [127:0] in_key, in_block;
  logic         out_valid, out_ready;
  logic [127:0] out_data;
  logic         out_err, busy, core_rst;
  logic [7:0]   core_key, core_data, core_dout;
  logic         core_dvalid;

  int n_vec = 0;
  int n_err = 0;
  bit mute  = 1'b0;

  aes_stream_ctrl #(.RST_CYC(TB_RST), .TIMEOUT_CYC(TB_TMO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key), .in_block(in_block),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .busy(busy), .core_rst(core_rst), .core_key(core_key), .core_data(core_data),
    .core_dout(core_dout), .core_dvalid(core_dvalid)
  );

  always #5 clk = ~clk;

  // Known AES-128 answers for the two reference vectors, otherwise an arbitrary
  // but key- and order-sensitive stand-in for the cipher.
  function automatic logic [127:0] cipher_fn(input logic [127:0] k, input logic [127:0] p);
    logic [127:0] x;
    if (k == C1_KEY && p == C1_PT) return C1_CT;
    if (k == 128'd0 && p == 128'd0) return Z_CT;
    x = k ^ {p[119:0], p[127:120]};
    return x ^ 128'h5a3c_96e1_0f87_d24b_a5c3_691e_f078_2db4;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Core model
  initial begin : core_model
    logic [127:0] ck, cd, ct;
    int ld, oi, wt;
    core_dvalid = 1'b0;
    core_dout   = 8'h00;
    ld = 0; oi = 16; wt = 0; ck = '0; cd = '0; ct = '0;
    forever begin
      @(posedge clk); #1;
      core_dvalid = 1'b0;
      core_dout   = 8'h00;
      if (rst || core_rst) begin
        ld = 0;
        oi = 16;
      end else if (ld < 16) begin
        ck[127-8*ld -: 8] = core_key;
        cd[127-8*ld -: 8] = core_data;
        ld++;
        if (ld == 16) begin
          ct = cipher_fn(ck, cd);
          oi = 0;
          wt = $urandom_range(0, 8);
        end
      end else if (!mute && oi < 16) begin
        if (wt > 0) wt--;
        else begin
          core_dvalid = 1'b1;
          core_dout   = ct[127-8*oi -: 8];
          oi++;
          wt = $urandom_range(0, 2);
        end
      end
    end
  end

  task automatic run_job(input logic [127:0] k, input logic [127:0] p, input bit mute_i,
                         input int stall, input bit inject);
    logic [127:0] exp_d;
    int n, m;
    exp_d = mute_i ? 128'd0 : cipher_fn(k, p);
    mute  = mute_i;
    @(negedge clk);
    in_valid = 1'b1; in_key = k; in_block = p;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    chk("in_ready_idle", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0; in_key = rnd128(); in_block = rnd128();
    @(negedge clk);
    chk("busy_accept", 128'(busy), 128'(1));
    chk("in_ready_busy", 128'(in_ready), 128'(0));
    n = 0;
    while (core_rst && n < 50) begin n++; @(negedge clk); end
    chk("crst_cycles", 128'(n), 128'(TB_RST));
    chk("load_byte0", {112'd0, core_key, core_data}, {112'd0, k[127:120], p[127:120]});
    m = n;
    while (!out_valid && m < 400) begin
      if (inject) begin
        in_valid = 1'($urandom_range(0, 1)); in_key = rnd128(); in_block = rnd128();
      end
      m++;
      @(negedge clk);
    end
    chk("out_valid", 128'(out_valid), 128'(1));
    if (mute_i) chk("tmo_cycles", 128'(m), 128'(TB_RST + 16 + TB_TMO));
    chk("out_data", out_data, exp_d);
    chk("out_err", 128'(out_err), 128'(mute_i));
    chk("core_rst_hold", 128'(core_rst), 128'(1));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("hold_stable", {out_valid, out_err, out_data[125:0]}, {1'b1, mute_i, exp_d[125:0]});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    chk("post_out_valid", 128'(out_valid), 128'(0));
    chk("post_in_ready", {126'd0, in_ready, busy}, {126'd0, 1'b1, 1'b0});
    mute = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    rst = 1'b1; in_valid = 1'b0; in_key = '0; in_block = '0; out_ready = 1'b0;
    #1;
    chk("rst_ready_busy", {124'd0, in_ready, busy, out_valid, out_err}, {124'd0, 4'b1000});
    chk("rst_core", {111'd0, core_rst, core_key, core_data}, {111'd0, 1'b1, 16'h0000});
    chk("rst_data", out_data, 128'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_job(C1_KEY, C1_PT, 1'b0, 0, 1'b0);
    run_job(C1_KEY, C1_PT, 1'b0, 20, 1'b0);
    run_job(C1_KEY, C1_PT, 1'b0, 0, 1'b1);
    run_job(rnd128(), rnd128(), 1'b1, 2, 1'b0);

    // Reset mid-load at byte 7
    @(negedge clk);
    in_valid = 1'b1; in_key = C1_KEY; in_block = C1_PT;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (core_rst && n < 50) begin n++; @(negedge clk); end
    repeat (7) @(negedge clk);
    chk("load_byte7", {112'd0, core_key, core_data}, {112'd0, C1_KEY[71:64], C1_PT[71:64]});
    rst = 1'b1;
    #1;
    chk("abort_ready_busy", {124'd0, in_ready, busy, out_valid, out_err}, {124'd0, 4'b1000});
    chk("abort_core", {111'd0, core_rst, core_key, core_data}, {111'd0, 1'b1, 16'h0000});
    chk("abort_data", out_data, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    run_job(C1_KEY, C1_PT, 1'b0, 1, 1'b0);

    run_job(C1_KEY, C1_PT, 1'b0, 0, 1'b0);
    run_job(128'd0, 128'd0, 1'b0, 0, 1'b0);

    for (int j = 0; j < 24; j++)
      run_job(rnd128(), rnd128(), ($urandom_range(0, 9) == 0), $urandom_range(0, 4),
              1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
